// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and types for the two-level carry-lookahead adder.
//   ADD_WIDTH      operand width (the only supported width is 32)
//   ADD_GROUP_W    bits per first-level lookahead group
//   ADD_NUM_GROUPS number of first-level groups (two super-groups of four)
//   add_word_t     one operand / sum word
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADD_WIDTH      = 32;
    localparam int ADD_GROUP_W    = 4;
    localparam int ADD_NUM_GROUPS = 8;

    typedef logic [ADD_WIDTH-1:0] add_word_t;

endpackage : adder_pkg

// File: rtl/cla4_block.sv
// -----------------------------------------------------------------------------
// cla4_block
// Four-input carry-lookahead unit. Used both for a 4-bit group (bit-level p/g)
// and for a super-group of four groups (group-level P/G); the equations are
// identical in both roles.
// Ports:
//   p[3:0]  propagate terms
//   g[3:0]  generate terms
//   c0      carry into position 0
//   c[3:1]  lookahead carries into positions 1..3
//   grp_p   block propagate  (all four positions propagate)
//   grp_g   block generate   (carry produced inside the block)
// The carry out of position 3 is not produced here; the next level forms it
// from grp_p/grp_g so the lookahead stays two-level rather than rippling.
// -----------------------------------------------------------------------------
module cla4_block (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       c0,
    output logic [3:1] c,
    output logic       grp_p,
    output logic       grp_g
);

    // Every carry is a flat sum of products of p/g and c0 -- no carry feeds
    // another carry inside the block.
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);

    // Block terms are independent of c0, which keeps the hierarchy free of
    // combinational loops even though carries flow back down into the groups.
    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule : cla4_block

// File: rtl/adder_ch_32bit.sv
// -----------------------------------------------------------------------------
// adder_ch_32bit
// 32-bit two-level carry-lookahead adder with carry-in and carry-out and a
// single output register stage. One add is accepted every clock; there is no
// handshake -- op1/op2/cin are sampled on every rising edge and the result is
// visible on sum/cout after that same edge.
// Parameters:
//   WIDTH    operand width, must be 32
//   GROUP_W  first-level group width, must be 4
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears sum/cout, wins over capture
//   op1   operand A
//   op2   operand B
//   cin   carry into bit 0
//   sum   registered (op1 + op2 + cin) mod 2^32
//   cout  registered carry out of bit 31
// Structure: bit p/g -> eight 4-bit lookahead groups -> two super-groups of
// four groups -> carry vector -> sum XOR -> output flops.
// -----------------------------------------------------------------------------
module adder_ch_32bit
    import adder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The lookahead tree below is hard-wired for 8 groups of 4.
    if (WIDTH != ADD_WIDTH || GROUP_W != ADD_GROUP_W) begin : g_bad_cfg
        $error("adder_ch_32bit: only WIDTH=32 and GROUP_W=4 are supported");
    end

    add_word_t                 bit_p;
    add_word_t                 bit_g;
    add_word_t                 carry;     // carry into each bit position
    add_word_t                 sum_d;
    logic [ADD_NUM_GROUPS-1:0] grp_p;
    logic [ADD_NUM_GROUPS-1:0] grp_g;
    logic [ADD_NUM_GROUPS-1:0] grp_c;     // carry into each group
    logic [1:0]                sup_p;
    logic [1:0]                sup_g;
    logic                      c16;
    logic                      c32;

    assign bit_p = op1 ^ op2;
    assign bit_g = op1 & op2;

    // First level: one lookahead unit per 4-bit group. Bit 0 of each group
    // takes the group carry directly; bits 1..3 come from the unit.
    for (genvar k = 0; k < ADD_NUM_GROUPS; k++) begin : g_grp
        cla4_block u_grp (
            .p     (bit_p[k*ADD_GROUP_W +: ADD_GROUP_W]),
            .g     (bit_g[k*ADD_GROUP_W +: ADD_GROUP_W]),
            .c0    (grp_c[k]),
            .c     (carry[k*ADD_GROUP_W+1 +: ADD_GROUP_W-1]),
            .grp_p (grp_p[k]),
            .grp_g (grp_g[k])
        );
        assign carry[k*ADD_GROUP_W] = grp_c[k];
    end

    // Second level: groups 0..3 and 4..7 each form a super-group. The
    // super-group units supply the carries into groups 1..3 and 5..7.
    cla4_block u_sup0 (
        .p     (grp_p[3:0]),
        .g     (grp_g[3:0]),
        .c0    (cin),
        .c     (grp_c[3:1]),
        .grp_p (sup_p[0]),
        .grp_g (sup_g[0])
    );

    cla4_block u_sup1 (
        .p     (grp_p[7:4]),
        .g     (grp_g[7:4]),
        .c0    (c16),
        .c     (grp_c[7:5]),
        .grp_p (sup_p[1]),
        .grp_g (sup_g[1])
    );

    assign c16      = sup_g[0] | (sup_p[0] & cin);
    assign c32      = sup_g[1] | (sup_p[1] & c16);
    assign grp_c[0] = cin;
    assign grp_c[4] = c16;

    assign sum_d = bit_p ^ carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_d;
            cout <= c32;
        end
    end

endmodule : adder_ch_32bit

// File: tb/tb_adder_ch_32bit.sv
// -----------------------------------------------------------------------------
// tb_adder_ch_32bit
// Directed and random vectors for adder_ch_32bit. Each cycle the driver
// first checks the DUT output produced by the previous edge against the head
// of the expected queue, then applies the next vector and pushes its expected
// {cout,sum}. This checks the one-cycle latency and back-to-back behaviour on
// every vector.
// -----------------------------------------------------------------------------
module tb_adder_ch_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    adder_ch_32bit #(.WIDTH(32), .GROUP_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .op1  (op1),
        .op2  (op2),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst = 1'b1;
        op1 = '0;
        op2 = '0;
        cin = 1'b0;
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [32:0] got,
                             input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare the output of the last edge against the oldest expectation.
    task automatic score(input string tag);
        logic [32:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val(tag, {cout, sum}, e);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge so they are stable at the rising edge.
    task automatic drive(input string tag, input logic r, input logic [31:0] a,
                         input logic [31:0] b, input logic ci,
                         input logic [32:0] exp);
        @(negedge clk);
        score(tag);
        rst = r;
        op1 = a;
        op2 = b;
        cin = ci;
        exp_q.push_back(r ? 33'h0 : exp);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            score(tag);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        n_checks = 0;
        n_errors = 0;

        // Reset held with all-ones operands: output must stay cleared.
        drive("rst_hold", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0);
        drive("rst_hold", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0);
        drive("rst_hold", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h0);
        // Release: first result one cycle later.
        drive("rst_rel", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);

        // Walking ones, cin = 0 and cin = 1.
        for (int i = 0; i < 32; i++) begin
            drive("walk_c0", 1'b0, 32'h1 << i, 32'h1 << i, 1'b0,
                  (i == 31) ? 33'h1_0000_0000 : 33'(64'h2 << i));
        end
        for (int i = 0; i < 32; i++) begin
            drive("walk_c1", 1'b0, 32'h1 << i, 32'h1 << i, 1'b1,
                  (i == 31) ? 33'h1_0000_0001 : 33'((64'h2 << i) + 64'h1));
        end

        // Long propagate chains and boundaries.
        drive("prop_c0",  1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 33'h0_FFFF_FFFF);
        drive("prop_c1",  1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 33'h1_0000_0000);
        drive("full_prop",1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        drive("zero",     1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
        drive("two_32",   1'b0, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 33'h1_0000_0000);

        // Back-to-back distinct results.
        drive("pipe", 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 33'h0_0000_0003);
        drive("pipe", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
        drive("pipe", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001);
        drive("pipe", 1'b0, 32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
        drive("pipe", 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 33'h1_0000_0000);
        drive("pipe", 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000);

        // Reset mid-stream: the vector applied under reset is discarded.
        drive("mid_pre", 1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, 33'h0_0000_0030);
        drive("mid_rst", 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h0);
        drive("mid_rel", 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);

        // Random vectors against a 33-bit behavioural add.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            drive("random", 1'b0, ra, rb, rc,
                  {1'b0, ra} + {1'b0, rb} + {32'h0, rc});
        end

        drain("drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_adder_ch_32bit
